// File: rtl/somador_completo.sv
// Parameterizable ripple-carry full adder with combinational sum/carry/propagate/generate
// outputs and a registered, valid-flagged copy of the result for pipelined consumers.
module somador_completo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] R,
  output logic             Cout,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] R_q,
  output logic             Cout_q,
  output logic             valid_q
);

  // Bit-serial ripple: the carry is a scalar local, so no signal feeds back on itself.
  function automatic logic [WIDTH:0] ripple_add(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             c_in
  );
    logic [WIDTH-1:0] s;
    logic             c;
    c = c_in;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             vld_d, vld_q;

  // Combinational adder path, independent of clock and reset.
  always_comb begin
    sum_s = ripple_add(A, B, Cin);
    R     = sum_s[WIDTH-1:0];
    Cout  = sum_s[WIDTH];
    P     = A ^ B;
    G     = A & B;
  end

  // Next-state for the result registers: capture on en, otherwise hold and drop valid.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    vld_d   = 1'b0;
    if (en) begin
      sum_d   = R;
      carry_d = Cout;
      vld_d   = 1'b1;
    end else begin
      sum_d   = sum_q;
      carry_d = carry_q;
      vld_d   = 1'b0;
    end
  end

  // Result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
    end
  end

  assign R_q     = sum_q;
  assign Cout_q  = carry_q;
  assign valid_q = vld_q;

endmodule

// File: tb/tb_somador_completo.sv
// Self-checking bench: table vectors for WIDTH=1 and WIDTH=4, hand sequences for
// capture/hold/reset, and randomized WIDTH=4 traffic against an arithmetic model.
module tb_somador_completo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic [0:0] r1, p1, g1, rq1;
  logic       cout1, coutq1, vq1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic [3:0] r4, p4, g4, rq4;
  logic       cout4, coutq4, vq4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  somador_completo #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a1), .B(b1), .Cin(cin1),
    .R(r1), .Cout(cout1), .P(p1), .G(g1), .R_q(rq1), .Cout_q(coutq1), .valid_q(vq1)
  );

  somador_completo #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a4), .B(b4), .Cin(cin4),
    .R(r4), .Cout(cout4), .P(p4), .G(g4), .R_q(rq4), .Cout_q(coutq4), .valid_q(vq4)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_r;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t tbl1[8];
  vec_t tbl4[4];
  logic [4:0] m_sum;
  logic [3:0] m_r;
  logic       m_c, m_v;

  initial begin
    // WIDTH=1 exhaustive truth table, expected values written out by hand
    tbl1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
    tbl1[1] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b0};
    tbl1[2] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b0};
    tbl1[3] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
    tbl1[4] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
    tbl1[5] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b1};
    tbl1[6] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b1};
    tbl1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1};
    tbl4[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl4[1] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
    tbl4[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    tbl4[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};

    // Reset held with en=1 and clock running
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rq1", rq1, 0);
    chk("rst_coutq1", coutq1, 0);
    chk("rst_vq1", vq1, 0);
    chk("rst_rq4", rq4, 0);
    chk("rst_vq4", vq4, 0);
    chk("rst_comb_r1", r1, 0);
    chk("rst_comb_cout1", cout1, 1);
    chk("rst_comb_r4", r4, 4'h2);
    chk("rst_comb_cout4", cout4, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = tbl1[i].a[0:0]; b1 = tbl1[i].b[0:0]; cin1 = tbl1[i].cin;
      #1;
      chk($sformatf("w1_r_%0d", i), r1, tbl1[i].exp_r);
      chk($sformatf("w1_cout_%0d", i), cout1, tbl1[i].exp_cout);
    end

    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; #1;
    chk("pg_p_10", p1, 1); chk("pg_g_10", g1, 0);
    a1 = 1'b1; b1 = 1'b1; #1;
    chk("pg_p_11", p1, 0); chk("pg_g_11", g1, 1);
    a4 = 4'b1100; b4 = 4'b1010; #1;
    chk("pg_p4", p4, 4'b0110); chk("pg_g4", g4, 4'b1000);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = tbl4[i].a; b4 = tbl4[i].b; cin4 = tbl4[i].cin;
      #1;
      chk($sformatf("w4_r_%0d", i), r4, tbl4[i].exp_r);
      chk($sformatf("w4_cout_%0d", i), cout4, tbl4[i].exp_cout);
    end

    // Capture then hold
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("cap_rq", rq1, 1); chk("cap_coutq", coutq1, 1); chk("cap_vq", vq1, 1);
    @(negedge clk);
    en = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    chk("hold_rq", rq1, 1); chk("hold_coutq", coutq1, 1); chk("hold_vq", vq1, 0);

    // Mid-operation asynchronous reset between edges
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_vq", vq1, 1); chk("pre_rst_coutq", coutq1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rq", rq1, 0); chk("mid_rst_coutq", coutq1, 0); chk("mid_rst_vq", vq1, 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_noen_vq", vq1, 0); chk("post_rst_noen_coutq", coutq1, 0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    chk("first_cap_vq", vq1, 1); chk("first_cap_coutq", coutq1, 1); chk("first_cap_rq", rq1, 0);

    // Randomized WIDTH=4 traffic against an arithmetic model of the registered copy
    @(negedge clk);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    m_r = 4'h0; m_c = 1'b0; m_v = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      #1;
      m_sum = 5'(int'(a4) + int'(b4) + int'(cin4));
      chk("rnd_r", r4, m_sum[3:0]);
      chk("rnd_cout", cout4, m_sum[4]);
      chk("rnd_p", p4, a4 ^ b4);
      chk("rnd_g", g4, a4 & b4);
      @(posedge clk);
      if (en) begin
        m_r = m_sum[3:0]; m_c = m_sum[4]; m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      #1;
      chk("rnd_rq", rq4, m_r);
      chk("rnd_coutq", coutq4, m_c);
      chk("rnd_vq", vq4, m_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
